// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory bridge.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store enables/replication and load extraction.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] word,
  output logic [31:0] ld_value
);

  logic [31:0] shifted;
  logic        sx;

  always_comb begin
    be   = 4'hF;
    wrep = wdata;
    case (size)
      SZ_B: begin
        be   = 4'b0001 << off;
        wrep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be   = 4'b0011 << off;
        wrep = {2{wdata[15:0]}};
      end
      default: begin
        be   = 4'hF;
        wrep = wdata;
      end
    endcase
  end

  always_comb begin
    shifted  = word >> {ld_off, 3'b000};
    sx       = 1'b0;
    ld_value = shifted;
    case (ld_size)
      SZ_B: begin
        sx       = ~ld_unsigned & shifted[7];
        ld_value = {{24{sx}}, shifted[7:0]};
      end
      SZ_H: begin
        sx       = ~ld_unsigned & shifted[15];
        ld_value = {{16{sx}}, shifted[15:0]};
      end
      default: ld_value = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Core data port to req/ack memory bridge with stall, lane steering,
// misalignment detection and a bounded wait for the memory ack.
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  state_t      state;
  state_t      nxt;
  logic [15:0] cnt;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [3:0]  be_c;
  logic [31:0] wrep_c;
  logic [31:0] ld_val;
  logic        bad;
  logic        expired;

  assign bad     = misaligned(req_size, req_adr[1:0]);
  assign expired = (cnt == 16'(TIMEOUT - 1));

  lsu_lane u_lane (
    .size        (req_size),
    .off         (req_adr[1:0]),
    .wdata       (req_wdata),
    .be          (be_c),
    .wrep        (wrep_c),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (uns_q),
    .word        (mem_rdata),
    .ld_value    (ld_val)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req_valid) nxt = bad ? DONE : WAIT;
      WAIT:    if (mem_ack || expired) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid && bad) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (req_valid) begin
            err_q   <= 1'b0;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            off_q   <= req_adr[1:0];
            adr_q   <= {req_adr[ADDR_W-1:2], 2'b00};
            be_q    <= be_c;
            wdata_q <= req_we ? wrep_c : 32'h0;
          end
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (mem_ack) begin
            rdata_q <= we_q ? 32'h0 : ld_val;
            err_q   <= 1'b0;
          end else if (expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: err_q <= 1'b0;
      endcase
    end
  end

  assign stall       = req_valid && (state != DONE);
  assign mem_req     = (state == WAIT);
  assign mem_we      = we_q && (state == WAIT);
  assign mem_adr     = adr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign rdata_valid = (state == DONE);
  assign rdata       = rdata_q;
  assign err         = err_q;

endmodule
